// File: rtl/vga_mem_arbiter.sv
// Arbitrates the single-port display/glyph memory between the VGA fetch path and the CPU.
// VGA has priority; a saturating wait counter lets a starved CPU win one slot.
module vga_mem_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned CPU_MAX_WAIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vga_req_i,
  input  logic [ADDR_W-1:0] vga_addr_i,
  output logic              vga_ack_o,
  output logic [DATA_W-1:0] vga_rdata_o,
  output logic              vga_rvalid_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_rvalid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned WaitW = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WaitW-1:0] MaxWait = WaitW'(CPU_MAX_WAIT);

  typedef enum logic [1:0] {OwnIdle, OwnVga, OwnCpu} owner_e;

  owner_e            owner_q, owner_d;
  logic [WaitW-1:0]  cpu_wait_q, cpu_wait_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] vga_rdata_q, cpu_rdata_q;

  // Tag bit 1 = VGA read, bit 0 = CPU read; a write travels as 00.
  logic [MEM_LAT-1:0][1:0] tag_q, tag_d;
  logic [1:0]              tag_in;

  logic vga_elig, cpu_elig;

  assign vga_ack_o = (owner_q == OwnVga);
  assign cpu_ack_o = (owner_q == OwnCpu);

  // Arbitration decision for the next issue cycle.
  always_comb begin
    vga_elig    = vga_req_i & ~vga_ack_o;
    cpu_elig    = cpu_req_i & ~cpu_ack_o;
    owner_d     = OwnIdle;
    cpu_wait_d  = cpu_wait_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;

    if (vga_elig && cpu_elig && (cpu_wait_q == MaxWait)) begin
      owner_d = OwnCpu;
    end else if (vga_elig) begin
      owner_d = OwnVga;
    end else if (cpu_elig) begin
      owner_d = OwnCpu;
    end

    if (owner_d == OwnCpu) begin
      cpu_wait_d = '0;
    end else if (cpu_elig && (cpu_wait_q != MaxWait)) begin
      cpu_wait_d = cpu_wait_q + 1'b1;
    end

    unique case (owner_d)
      OwnVga: begin
        mem_addr_d = vga_addr_i;
      end
      OwnCpu: begin
        mem_addr_d  = cpu_addr_i;
        mem_wdata_d = cpu_wdata_i;
        mem_we_d    = cpu_we_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    tag_in    = {owner_q == OwnVga, (owner_q == OwnCpu) & ~mem_we_q};
    tag_d     = tag_q;
    tag_d[0]  = tag_in;
    for (int i = 1; i < MEM_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q     <= OwnIdle;
      cpu_wait_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      tag_q       <= '0;
      vga_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      cpu_wait_q  <= cpu_wait_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      tag_q       <= tag_d;
      if (vga_rvalid_o) vga_rdata_q <= mem_rdata_i;
      if (cpu_rvalid_o) cpu_rdata_q <= mem_rdata_i;
    end
  end

  assign vga_rvalid_o = tag_q[MEM_LAT-1][1];
  assign cpu_rvalid_o = tag_q[MEM_LAT-1][0];

  // Memory data is only valid in the rvalid cycle, so pass it through then and hold it after.
  assign vga_rdata_o = vga_rvalid_o ? mem_rdata_i : vga_rdata_q;
  assign cpu_rdata_o = cpu_rvalid_o ? mem_rdata_i : cpu_rdata_q;

  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
